pdm_deserializer: RTL and testbench

Capture stage feeding the record path. It generates the PDM microphone clock and samples the microphone's 1-bit data stream. It packs WORD_BITS consecutive bits into a word and presents it to the controller/memory with a one-cycle done pulse. It is gated entirely by the controller's deserializer enable; the controller's address counter advances on each done pulse.

---
 rtl/audio_pkg.sv | 14 +
 rtl/pdm_clock_gen.sv | 51 +++++
 rtl/pdm_deserializer.sv | 101 ++++++++++
 tb/tb_pdm_deserializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio record path: deserializer state encoding
// and the PDM timing constants used by the controller, timer and capture stage.
package audio_pkg;

    typedef enum logic {
        DESER_STATE_IDLE = 1'b0,
        DESER_STATE_RUN  = 1'b1
    } deserializer_state_t;

    // 100 MHz / 40 = 2.5 MHz microphone clock
    localparam int PDM_CLK_DIV   = 40;
    localparam int PDM_WORD_BITS = 16;

endpackage

// File: rtl/pdm_clock_gen.sv
// PDM microphone clock divider. Produces a 50% duty clock that starts high on
// the first run cycle, and a strobe in the last cycle of each high phase.
module pdm_clock_gen
    import audio_pkg::*;
#(
    parameter int CLK_DIV = PDM_CLK_DIV
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic run,
    output logic pdm_clk_o,
    output logic sample_stb_o
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = $clog2(CLK_DIV);

    // run is the *next* state of the capture FSM, so active mirrors the
    // registered state and lets the first run cycle start cleanly at zero.
    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;
    logic          active;

    // Next divider value: held at zero outside run and on the entry edge.
    always_comb begin
        div_nxt = '0;
        if (run && active) begin
            if (div_cnt == CW'(CLK_DIV - 1)) begin
                div_nxt = '0;
            end else begin
                div_nxt = div_cnt + 1'b1;
            end
        end
    end

    // Divider state and registered PDM clock, aligned to the divider value.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            div_cnt   <= '0;
            active    <= 1'b0;
            pdm_clk_o <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            active    <= run;
            pdm_clk_o <= run && (div_nxt < CW'(HALF));
        end
    end

    assign sample_stb_o = active && (div_cnt == CW'(HALF - 1));

endmodule

// File: rtl/pdm_deserializer.sv
// PDM capture stage: synchronizes the microphone bit stream, packs WORD_BITS
// samples MSB-first into a word and flags each completed word with done_o.
module pdm_deserializer
    import audio_pkg::*;
#(
    parameter int CLK_DIV   = PDM_CLK_DIV,
    parameter int WORD_BITS = PDM_WORD_BITS
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 pdm_data_i,
    output logic                 pdm_clk_o,
    output logic                 pdm_lrsel_o,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 done_o
);

    localparam int BW = $clog2(WORD_BITS);

    deserializer_state_t  state;
    deserializer_state_t  state_nxt;
    logic                 run_nxt;
    logic                 sync_p0;
    logic                 sync_p1;
    logic [WORD_BITS-1:0] shift;
    logic [BW-1:0]        bit_cnt;
    logic                 sample_stb;

    assign pdm_lrsel_o = 1'b0;
    assign run_nxt     = (state_nxt == DESER_STATE_RUN);

    pdm_clock_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clock_gen (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .run         (run_nxt),
        .pdm_clk_o   (pdm_clk_o),
        .sample_stb_o(sample_stb)
    );

    // Two-flop synchronizer for the asynchronous microphone data.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pdm_data_i;
            sync_p1 <= sync_p0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= DESER_STATE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: follows the controller enable level.
    always_comb begin
        state_nxt = state;
        case (state)
            DESER_STATE_IDLE: if (enable_i)  state_nxt = DESER_STATE_RUN;
            DESER_STATE_RUN:  if (!enable_i) state_nxt = DESER_STATE_IDLE;
            default:          state_nxt = DESER_STATE_IDLE;
        endcase
    end

    // Shift/pack datapath. A word completing on the same edge that leaves RUN
    // is still delivered; any partial word is dropped when leaving RUN.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            shift   <= '0;
            bit_cnt <= '0;
            data_o  <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if ((state == DESER_STATE_RUN) && sample_stb) begin
                if (bit_cnt == BW'(WORD_BITS - 1)) begin
                    data_o  <= {shift[WORD_BITS-2:0], sync_p1};
                    done_o  <= 1'b1;
                    shift   <= '0;
                    bit_cnt <= '0;
                end else begin
                    shift   <= {shift[WORD_BITS-2:0], sync_p1};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (!run_nxt) begin
                shift   <= '0;
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_deserializer.sv
// Self-checking bench for pdm_deserializer: default instance driven by a
// microphone model with a word scoreboard, plus a small-parameter instance.
module tb_pdm_deserializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pdm_data;
    logic        pdm_clk;
    logic        lrsel;
    logic [15:0] data;
    logic        done;

    logic        en2;
    logic        pdm_data2;
    logic        pdm_clk2;
    logic        lrsel2;
    logic [7:0]  data2;
    logic        done2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pdm_deserializer dut (
        .clock_i    (clk),
        .reset_i    (rst_n),
        .enable_i   (enable),
        .pdm_data_i (pdm_data),
        .pdm_clk_o  (pdm_clk),
        .pdm_lrsel_o(lrsel),
        .data_o     (data),
        .done_o     (done)
    );

    pdm_deserializer #(.CLK_DIV(4), .WORD_BITS(8)) dut_small (
        .clock_i    (clk),
        .reset_i    (rst_n),
        .enable_i   (en2),
        .pdm_data_i (pdm_data2),
        .pdm_clk_o  (pdm_clk2),
        .pdm_lrsel_o(lrsel2),
        .data_o     (data2),
        .done_o     (done2)
    );

    // Microphone model: presents bit mic_bits[k] after the k-th falling edge
    // of pdm_clk since loading; outside the pattern it outputs fill_bit.
    int   fall_cnt = 0;
    int   mic_base = 0;
    int   mic_n    = 0;
    int   mic_idx;
    logic fill_bit;
    logic mic_bits [64];

    always @(negedge pdm_clk) fall_cnt++;

    assign mic_idx   = fall_cnt - mic_base;
    assign pdm_data  = (mic_idx >= 0 && mic_idx < mic_n) ? mic_bits[mic_idx[5:0]] : fill_bit;
    assign pdm_data2 = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected word.
    logic [15:0] expq [$];
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (expq.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                check("word", {16'd0, data}, {16'd0, expq.pop_front()});
            end
        end
        prev_done = done;
    end

    // Count negedges until done (bounded); optionally verify the clock shape
    // over the first two PDM periods counted from RUN cycle 0.
    task automatic wait_done(input bit chk_clk, input int limit, output int n);
        int bad;
        bad = 0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (chk_clk && n <= 80 && pdm_clk !== (((n - 1) % 40) < 20)) bad++;
        end while (!done && n < limit);
        if (chk_clk) check("clk_shape", bad, 0);
    endtask

    task automatic wait_done2(input bit chk_clk, input int limit, output int n);
        int bad;
        bad = 0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (chk_clk && n <= 16 && pdm_clk2 !== (((n - 1) % 4) < 2)) bad++;
        end while (!done2 && n < limit);
        if (chk_clk) check("clk2_shape", bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] pat;

        rst_n    = 1'b0;
        enable   = 1'b0;
        en2      = 1'b0;
        fill_bit = 1'b0;

        // Reset and idle with toggling microphone data.
        repeat (10) @(negedge clk) fill_bit = ~fill_bit;
        check("rst_outs", {14'd0, pdm_clk, done, data}, 32'd0);
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            fill_bit = ~fill_bit;
            check("idle_outs", {13'd0, lrsel, pdm_clk, done, data}, 32'd0);
        end

        // Constant ones: latency, clock shape, word period.
        fill_bit = 1'b1;
        repeat (4) @(negedge clk);
        expq.push_back(16'hFFFF);
        expq.push_back(16'hFFFF);
        enable = 1'b1;
        wait_done(1'b1, 700, n);
        check("ones_lat", n - 1, 620);
        wait_done(1'b0, 700, n);
        check("ones_period", n, 640);
        @(negedge clk);
        check("ones_pulse_end", {31'd0, done}, 32'd0);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Alternating bits then 0x1234, MSB first, aligned to the strobes.
        pat = {16'hAAAA, 16'h1234};
        for (int i = 0; i < 32; i++) mic_bits[i] = pat[31-i];
        mic_base = fall_cnt;
        mic_n    = 32;
        fill_bit = 1'b0;
        expq.push_back(16'hAAAA);
        expq.push_back(16'h1234);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        wait_done(1'b1, 700, n);
        check("pat_lat", n - 1, 620);
        wait_done(1'b0, 700, n);
        check("pat_period", n, 640);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        mic_n = 0;

        // Asynchronous reset in the middle of bit 9.
        fill_bit = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (365) @(negedge clk);
        check("pre_rst_data", {16'd0, data}, 32'h1234);
        check("pre_rst_clk", {31'd0, pdm_clk}, 32'd1);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_async", {14'd0, pdm_clk, done, data}, 32'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            check("post_rst_idle", {14'd0, pdm_clk, done, data}, 32'd0);
        end
        expq.push_back(16'hFFFF);
        enable = 1'b1;
        wait_done(1'b1, 700, n);
        check("post_rst_lat", n - 1, 620);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Abort after 7 bits of ones, re-enable with zeros.
        @(negedge clk);
        enable = 1'b1;
        repeat (285) @(negedge clk);
        enable   = 1'b0;
        fill_bit = 1'b0;
        repeat (50) begin
            @(negedge clk);
            check("abort_hold", {14'd0, pdm_clk, done, data}, {14'd0, 1'b0, 1'b0, 16'hFFFF});
        end
        expq.push_back(16'h0000);
        enable = 1'b1;
        wait_done(1'b1, 700, n);
        check("abort_lat", n - 1, 620);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Word completes as enable falls, then immediate re-enable.
        fill_bit = 1'b1;
        repeat (4) @(negedge clk);
        expq.push_back(16'hFFFF);
        enable = 1'b1;
        repeat (620) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("edge_done", {31'd0, done}, 32'd1);
        check("edge_clk", {31'd0, pdm_clk}, 32'd0);
        expq.push_back(16'hFFFF);
        enable = 1'b1;
        wait_done(1'b1, 700, n);
        check("reenable_lat", n - 1, 620);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Small-parameter instance: CLK_DIV=4, WORD_BITS=8.
        check("small_idle", {22'd0, lrsel2, pdm_clk2, done2, data2}, 32'd0);
        en2 = 1'b1;
        wait_done2(1'b1, 60, n);
        check("small_lat", n - 1, 30);
        check("small_word1", {24'd0, data2}, 32'hFF);
        wait_done2(1'b0, 60, n);
        check("small_period", n, 32);
        check("small_word2", {24'd0, data2}, 32'hFF);
        en2 = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
